// File: rtl/glb_stream_egress.sv
// rtl/glb_stream_egress.sv - token FIFO feeding the GLB sink, closing the stream after TX_NUM done tokens
module glb_stream_egress #(
  parameter int          DEPTH      = 4,
  parameter int          TX_NUM     = 1,
  parameter logic [16:0] DONE_TOKEN = 17'h10100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [16:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [16:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done,
  output logic [15:0] word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic          flush_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   done_seen_q, done_seen_d;
  logic [15:0]   word_count_q, word_count_d;
  logic [16:0]   mem [DEPTH];

  logic push;
  logic pop;
  logic done_hit;

  // Handshake and outputs: ready never looks at out_ready, so a full FIFO stays closed even while popping
  always_comb begin
    in_ready   = (state_q == STREAM) && (count_q < CW'(DEPTH));
    out_valid  = (state_q != IDLE) && (count_q != '0);
    out_data   = mem[rd_ptr_q];
    push       = in_valid && in_ready;
    pop        = out_valid && out_ready;
    done_hit   = push && (in_data == DONE_TOKEN);
    done       = (state_q == DONE);
    word_count = word_count_q;
  end

  // Next-state: flush overrides everything and discards the cycle's push/pop
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    done_seen_d  = done_seen_q;
    word_count_d = word_count_q;
    if (flush) begin
      state_d      = IDLE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      done_seen_d  = '0;
      word_count_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        if (word_count_q != 16'hFFFF) word_count_d = word_count_q + 16'd1;
      end
      if (push && !pop) count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
      if (done_hit) done_seen_d = done_seen_q + 16'd1;
      case (state_q)
        IDLE:    if (flush_q) state_d = STREAM;
        STREAM:  if (done_hit && ((done_seen_q + 16'd1) == 16'(TX_NUM))) state_d = DRAIN;
        DRAIN:   if (count_d == '0) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      flush_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      done_seen_q  <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      done_seen_q  <= done_seen_d;
      word_count_q <= word_count_d;
    end
  end

  // Token storage; contents are meaningless while occupancy is zero, so no reset
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_glb_stream_egress.sv
// tb/tb_glb_stream_egress.sv - directed self-checking bench for glb_stream_egress
module tb_glb_stream_egress;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [16:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready, out_valid, done;
  logic [16:0] out_data;
  logic [15:0] word_count;

  logic        in_ready2, out_valid2, done2;
  logic [16:0] out_data2;
  logic [15:0] word_count2;

  int          n_total;
  int          n_pass;
  logic [16:0] src[$];
  logic [16:0] got[$];
  int          idx;

  glb_stream_egress u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .word_count(word_count)
  );

  glb_stream_egress #(.TX_NUM(2)) u_dut_tx2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .done(done2), .word_count(word_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every token the sink accepts from the default instance
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: offer src[idx] if any remain, advance idx on acceptance
  task automatic step();
    in_valid = (idx < src.size());
    in_data  = (idx < src.size()) ? src[idx] : 17'h0;
    @(negedge clk);
    if (in_valid && in_ready) idx++;
    @(posedge clk);
    #1;
    in_valid = (idx < src.size());
    in_data  = (idx < src.size()) ? src[idx] : 17'h0;
  endtask

  task automatic flush_pulse();
    src.delete();
    idx   = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    got.delete();
  endtask

  initial begin
    int hi_seen;
    n_total   = 0;
    n_pass    = 0;
    idx       = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_word_count", word_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("idle_no_flush_in_ready", in_ready, 0);

    // Basic pass-through
    flush_pulse();
    check("pt_in_ready", in_ready, 1);
    out_ready = 1'b1;
    src = '{17'h00001, 17'h00002, 17'h10100};
    for (int c = 0; c < 20 && idx < 3; c++) step();
    check("pt_accepted", idx, 3);
    check("pt_drain_in_ready", in_ready, 0);
    check("pt_last_head", out_data, 17'h10100);
    check("pt_not_done_yet", done, 0);
    step();
    check("pt_done", done, 1);
    check("pt_word_count", word_count, 3);
    check("pt_out_valid", out_valid, 0);
    check("pt_got_n", got.size(), 3);
    if (got.size() == 3) begin
      check("pt_tok0", got[0], 17'h00001);
      check("pt_tok1", got[1], 17'h00002);
      check("pt_tok2", got[2], 17'h10100);
    end
    step();
    check("pt_done_persist", done, 1);

    // Backpressure
    out_ready = 1'b0;
    flush_pulse();
    check("bp_done_cleared", done, 0);
    for (int i = 0; i < 6; i++) src.push_back(17'h00100 + 17'(i));
    repeat (8) step();
    check("bp_accepted_full", idx, 4);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_hold", out_data, 17'h00100);
    out_ready = 1'b1;
    for (int c = 0; c < 30 && got.size() < 6; c++) step();
    check("bp_accepted_all", idx, 6);
    check("bp_got_n", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) check("bp_order", got[i], 17'h00100 + 17'(i));
    check("bp_word_count", word_count, 6);

    // Simultaneous push/pop at occupancy 2 across pointer wrap
    out_ready = 1'b0;
    flush_pulse();
    for (int i = 0; i < 12; i++) src.push_back(17'h00200 + 17'(i));
    repeat (2) step();
    check("sim_occ2", idx, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("sim_occ_hold", idx - got.size(), 2);
    end
    for (int c = 0; c < 10 && got.size() < 12; c++) step();
    check("sim_got_n", got.size(), 12);
    for (int i = 0; i < 12 && i < got.size(); i++) check("sim_order", got[i], 17'h00200 + 17'(i));
    check("sim_word_count", word_count, 12);

    // Flush mid-stream
    out_ready = 1'b0;
    flush_pulse();
    src = '{17'h00300, 17'h00301, 17'h00302};
    repeat (4) step();
    check("fl_buffered", idx, 3);
    check("fl_out_valid_pre", out_valid, 1);
    flush = 1'b1;
    repeat (2) step();
    check("fl_out_valid", out_valid, 0);
    check("fl_word_count", word_count, 0);
    check("fl_in_ready", in_ready, 0);
    flush = 1'b0;
    src.delete();
    idx = 0;
    step();
    check("fl_restart_ready", in_ready, 1);
    check("fl_restart_empty", out_valid, 0);
    got.delete();
    out_ready = 1'b1;
    src = '{17'h00003, 17'h10050, 17'h10100};
    for (int c = 0; c < 20 && !done; c++) step();
    check("fl_new_done", done, 1);
    check("fl_new_word_count", word_count, 3);
    check("fl_new_got_n", got.size(), 3);
    if (got.size() == 3) begin
      check("fl_new_tok0", got[0], 17'h00003);
      check("fl_new_ctrl", got[1], 17'h10050);
      check("fl_new_tok2", got[2], 17'h10100);
    end

    // Async reset in DRAIN
    out_ready = 1'b0;
    flush_pulse();
    src = '{17'h00400, 17'h00401, 17'h10100};
    for (int c = 0; c < 10 && idx < 3; c++) step();
    check("ar_in_drain_ready", in_ready, 0);
    check("ar_in_drain_valid", out_valid, 1);
    check("ar_in_drain_done", done, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 0);
    check("ar_word_count", word_count, 0);
    check("ar_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    src.delete();
    idx = 0;
    hi_seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (in_ready || out_valid) hi_seen++;
    end
    check("ar_idle_hold", hi_seen, 0);
    flush_pulse();
    check("ar_after_flush_ready", in_ready, 1);
    check("ar_tokens_discarded", out_valid, 0);

    // Two done tokens on the TX_NUM=2 instance
    out_ready = 1'b1;
    check("tx2_ready0", in_ready2, 1);
    in_valid = 1'b1;
    in_data  = 17'h00005;
    @(posedge clk); #1;
    in_data  = 17'h10100;
    @(posedge clk); #1;
    check("tx2_ready_after_first", in_ready2, 1);
    check("tx2_not_done_first", done2, 0);
    in_data  = 17'h00007;
    @(posedge clk); #1;
    in_data  = 17'h10100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("tx2_ready_after_second", in_ready2, 0);
    check("tx2_not_done_3pops", done2, 0);
    check("tx2_wc3", word_count2, 3);
    @(posedge clk); #1;
    check("tx2_done", done2, 1);
    check("tx2_wc4", word_count2, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/glb_stream_egress.md
GLB_STREAM_EGRESS -- requirements
Module: glb_stream_egress

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the FIFO entry count (power of two, at least 2).
REQ-002 The block SHALL have parameter TX_NUM, default 1, meaning the number of done tokens accepted before the stream closes.
REQ-003 The block SHALL have parameter DONE_TOKEN, default 17'h10100, meaning the 17-bit end-of-stream token value.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous stream restart.
REQ-007 The block SHALL have port in_data, input, 17 bits: the upstream token; bit 16 set marks a control token.
REQ-008 The block SHALL have port in_valid, input, 1 bit: upstream token present.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-010 The block SHALL have port out_data, output, 17 bits: the token presented to the GLB sink.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the GLB sink accepts out_data.
REQ-013 The block SHALL have port done, output, 1 bit: the stream has fully drained.
REQ-014 The block SHALL have port word_count, output, 16 bits: the number of tokens popped since the last flush.

Function
REQ-015 States SHALL be IDLE, STREAM, DRAIN and DONE.
REQ-016 A push SHALL occur when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-017 in_ready SHALL equal (state==STREAM) and (occupancy<DEPTH), with no combinational dependence on out_ready; when full, a simultaneous pop does not enable a push.
REQ-018 out_valid SHALL equal (occupancy!=0) in any state other than IDLE.
REQ-019 out_data SHALL be the FIFO head entry, combinational from storage, and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 Ordering SHALL be strictly FIFO; read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be DEPTH+1-valued (0..DEPTH).
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; empty-to-non-empty latency SHALL be one cycle (pushed token visible on out_data the next cycle).
REQ-022 A registered flush_q SHALL track flush; IDLE->STREAM SHALL occur on the cycle where flush_q=1 and flush=0 (the falling edge).
REQ-023 IDLE with no flush falling edge SHALL remain IDLE; in IDLE, in_ready=0 and out_valid=0.
REQ-024 A push with in_data==DONE_TOKEN SHALL increment done_seen; when the increment reaches TX_NUM, the state SHALL go STREAM->DRAIN on that edge, with the done token itself stored.
REQ-025 Control tokens other than DONE_TOKEN SHALL pass through unmodified and SHALL NOT be counted.
REQ-026 DRAIN->DONE SHALL occur on the edge where occupancy becomes 0; if occupancy is already 0 in DRAIN, the transition occurs on the next edge.
REQ-027 done SHALL be 1 exactly while state==DONE; DONE SHALL persist until flush or rst.
REQ-028 word_count SHALL increment on each pop and saturate at 16'hFFFF.
REQ-029 flush=1 in any state SHALL, on that edge, force IDLE, empty the FIFO, and clear done_seen, word_count and done; a push or pop in that cycle SHALL be discarded.

Reset
REQ-030 rst=1 SHALL asynchronously force state=IDLE, pointers=0, occupancy=0, done_seen=0, word_count=0, flush_q=0, done=0, in_ready=0 and out_valid=0; out_data is don't-care.
REQ-031 After rst deasserts, the block SHALL wait in IDLE for a full flush pulse; reset asserted mid-stream SHALL discard all buffered tokens.

Verification
REQ-032 Basic pass-through SHALL be covered: flush pulse, then push 0x00001, 0x00002, 0x10100 with out_ready=1 -> same three tokens out in order, done=1 one cycle after last pop, word_count=3.
REQ-033 Backpressure SHALL be covered: out_ready=0 and 6 offered tokens (DEPTH=4) -> exactly 4 accepted, in_ready=0 while full; out_ready=1 -> remaining 2 accepted, all 6 emitted in order.
REQ-034 Multiple done tokens SHALL be covered: TX_NUM=2, stream 0x00005, 0x10100, 0x00007, 0x10100 -> in_ready stays 1 after the first done token, drops after the second; done only after 4 pops.
REQ-035 Simultaneous push and pop at occupancy 2 SHALL be covered -> occupancy stays 2, order preserved across pointer wrap-around (at least 10 tokens through DEPTH=4).
REQ-036 Flush mid-stream SHALL be covered: 3 tokens buffered, flush=1 for 2 cycles -> out_valid=0, word_count=0; after flush falls, a new stream passes cleanly.
REQ-037 Async reset SHALL be covered: rst asserted between clock edges in DRAIN -> outputs reach reset values immediately; without a flush pulse, in_ready stays 0 for at least 10 cycles.
